// File: rtl/moving_forward.sv
// moving_forward: forward H-bridge drive with dead-time, IP steering, IR obstacle hold and a one-shot run timer
module moving_forward #(
  parameter int unsigned MOVE_CYCLES     = 500_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 200_000,
  parameter int unsigned DEADTIME_CYCLES = 1_000_000,
  parameter int unsigned BLOCK_TIMEOUT   = 300_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       canMove,
  input  logic       isMoving_reverse,
  input  logic       sensorIR_front,
  input  logic [3:0] sensIP_Front,
  input  logic [3:0] presentINs,
  output logic [3:0] sendToH_BridgeINs,
  output logic       isMoving_out
);
  localparam logic [3:0] FWD = 4'b1010, VEER_LEFT = 4'b0010, VEER_RIGHT = 4'b1000, OFF = 4'b0000;
  localparam logic [31:0] MOVE_MAX = 32'(MOVE_CYCLES), MOVE_LAST = 32'(MOVE_CYCLES - 1);
  localparam logic [31:0] DEAD_MAX = 32'(DEADTIME_CYCLES), DEAD_LAST = 32'(DEADTIME_CYCLES - 1);
  localparam logic [31:0] BLOCK_MAX = 32'(BLOCK_TIMEOUT), BLOCK_LAST = 32'(BLOCK_TIMEOUT - 1);
  localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, DEADTIME, DRIVE, BLOCKED, DONE} stateType;
  stateType state, nextState;
  logic [4:0] syncA, syncB, deb;
  logic [31:0] debCnt [5];
  logic [31:0] runTimer, deadTimer, blockTimer;
  logic leftHit, rightHit, abort, obstacle;
  logic [3:0] steer;
  assign obstacle = deb[4];
  assign leftHit = |deb[3:2];
  assign rightHit = |deb[1:0];
  assign steer = leftHit && !rightHit ? VEER_RIGHT : rightHit && !leftHit ? VEER_LEFT : FWD;
  assign abort = !canMove || isMoving_reverse;
  // Synchronize the raw sensors, then accept a change only after it has been stable long enough
  always_ff @(posedge clock) begin
    if (reset) begin
      syncA <= '0;
      syncB <= '0;
      deb <= '0;
      for (int i = 0; i < 5; i++) debCnt[i] <= '0;
    end else begin
      syncA <= {sensorIR_front, sensIP_Front};
      syncB <= syncA;
      for (int i = 0; i < 5; i++)
        if (syncB[i] == deb[i]) debCnt[i] <= '0;
        else if (debCnt[i] == DEB_LAST) begin
          deb[i] <= syncB[i];
          debCnt[i] <= '0;
        end else debCnt[i] <= debCnt[i] + 32'd1;
    end
  end
  // Next-state selection; abort outranks obstacle, which outranks run-time expiry
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (canMove && !isMoving_reverse && !obstacle) nextState = presentINs != OFF ? DEADTIME : DRIVE;
      DEADTIME: nextState = abort ? IDLE : deadTimer == DEAD_LAST ? DRIVE : DEADTIME;
      DRIVE:    nextState = abort ? IDLE : obstacle ? BLOCKED : runTimer == MOVE_LAST ? DONE : DRIVE;
      BLOCKED:  nextState = abort ? IDLE : !obstacle ? DRIVE : blockTimer == BLOCK_LAST ? DONE : BLOCKED;
      DONE:     nextState = canMove ? DONE : IDLE;
      default:  nextState = IDLE;
    endcase
  end
  // State, registered outputs derived from the next state, and saturating timers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sendToH_BridgeINs <= OFF;
      isMoving_out <= 1'b0;
      runTimer <= '0;
      deadTimer <= '0;
      blockTimer <= '0;
    end else begin
      state <= nextState;
      sendToH_BridgeINs <= nextState == DRIVE ? steer : OFF;
      isMoving_out <= nextState inside {DEADTIME, DRIVE, BLOCKED};
      runTimer <= state == IDLE ? '0 : state == DRIVE && runTimer != MOVE_MAX ? runTimer + 32'd1 : runTimer;
      deadTimer <= state != DEADTIME ? '0 : deadTimer == DEAD_MAX ? deadTimer : deadTimer + 32'd1;
      blockTimer <= state != BLOCKED ? '0 : blockTimer == BLOCK_MAX ? blockTimer : blockTimer + 32'd1;
    end
  end
endmodule

// File: tb/tb_moving_forward.sv
// tb_moving_forward: timed scoreboard bench for the forward-drive controller with short timing parameters
module tb_moving_forward;
  logic clock = 1'b0, reset = 1'b1, canMove = 1'b0, isMoving_reverse = 1'b0, sensorIR_front = 1'b0;
  logic [3:0] sensIP_Front = 4'b0000, presentINs = 4'b0000;
  logic [3:0] sendToH_BridgeINs;
  logic isMoving_out;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct { int at; logic [3:0] bridge; logic moving; string name; } expT;
  typedef struct { logic [3:0] ip; logic [3:0] bridge; } vecT;
  expT sb[$];
  vecT tbl[16];
  int k, g2, b, c, d, e;
  logic [3:0] prevBridge;
  moving_forward #(.MOVE_CYCLES(1000), .DEBOUNCE_CYCLES(8), .DEADTIME_CYCLES(20), .BLOCK_TIMEOUT(300)) dut (
    .clock(clock), .reset(reset), .canMove(canMove), .isMoving_reverse(isMoving_reverse),
    .sensorIR_front(sensorIR_front), .sensIP_Front(sensIP_Front), .presentINs(presentINs),
    .sendToH_BridgeINs(sendToH_BridgeINs), .isMoving_out(isMoving_out)
  );
  // Free-running clock and edge counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  // Pop every expectation due by the current edge and compare on the falling edge
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at <= cyc) begin
        checks++;
        if (sendToH_BridgeINs !== sb[i].bridge || isMoving_out !== sb[i].moving) begin
          errors++;
          $display("FAIL %s @edge %0d: got bridge=%b moving=%b, expected bridge=%b moving=%b",
                   sb[i].name, cyc, sendToH_BridgeINs, isMoving_out, sb[i].bridge, sb[i].moving);
        end
        sb.delete(i);
      end
  end
  // Bound the whole run
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic waitUntil(input int t);
    while (cyc < t) step(1);
  endtask
  task automatic expectAt(input int t, input logic [3:0] br, input logic mv, input string nm);
    sb.push_back('{t, br, mv, nm});
  endtask
  initial begin
    tbl[0] = '{4'h0, 4'b1010};  tbl[1] = '{4'h1, 4'b0010};  tbl[2] = '{4'h2, 4'b0010};  tbl[3] = '{4'h3, 4'b0010};
    tbl[4] = '{4'h4, 4'b1000};  tbl[5] = '{4'h5, 4'b1010};  tbl[6] = '{4'h6, 4'b1010};  tbl[7] = '{4'h7, 4'b1010};
    tbl[8] = '{4'h8, 4'b1000};  tbl[9] = '{4'h9, 4'b1010};  tbl[10] = '{4'hA, 4'b1010}; tbl[11] = '{4'hB, 4'b1010};
    tbl[12] = '{4'hC, 4'b1000}; tbl[13] = '{4'hD, 4'b1010}; tbl[14] = '{4'hE, 4'b1010}; tbl[15] = '{4'hF, 4'b1010};
    step(3);
    expectAt(cyc, 4'b0000, 1'b0, "resetState");
    reset = 1'b0;
    canMove = 1'b1;
    k = cyc;
    expectAt(k + 1, 4'b1010, 1'b1, "grant");
    expectAt(k + 1000, 4'b1010, 1'b1, "runLast");
    expectAt(k + 1001, 4'b0000, 1'b0, "runDone");
    step(4);
    prevBridge = 4'b1010;
    for (int i = 0; i < 16; i++) begin
      sensIP_Front = tbl[i].ip;
      expectAt(cyc + 10, prevBridge, 1'b1, "steerHold");
      expectAt(cyc + 11, tbl[i].bridge, 1'b1, "steer");
      prevBridge = tbl[i].bridge;
      step(50);
    end
    sensIP_Front = 4'b0001;
    expectAt(cyc + 11, 4'b1010, 1'b1, "glitchA");
    expectAt(cyc + 16, 4'b1010, 1'b1, "glitchB");
    step(5);
    sensIP_Front = 4'b1111;
    step(20);
    sensIP_Front = 4'b0000;
    waitUntil(k + 1060);
    expectAt(cyc, 4'b0000, 1'b0, "noRestart");
    canMove = 1'b0;
    step(3);
    canMove = 1'b1;
    expectAt(cyc + 1, 4'b1010, 1'b1, "regrant");
    step(10);
    isMoving_reverse = 1'b1;
    expectAt(cyc + 1, 4'b0000, 1'b0, "abortRev");
    step(5);
    expectAt(cyc, 4'b0000, 1'b0, "revHold");
    isMoving_reverse = 1'b0;
    g2 = cyc;
    expectAt(g2 + 1, 4'b1010, 1'b1, "revRelease");
    waitUntil(g2 + 100);
    b = cyc;
    sensorIR_front = 1'b1;
    expectAt(b + 10, 4'b1010, 1'b1, "preBlock");
    expectAt(b + 11, 4'b0000, 1'b1, "blocked");
    expectAt(b + 110, 4'b0000, 1'b1, "stillBlocked");
    expectAt(b + 111, 4'b1010, 1'b1, "resume");
    expectAt(g2 + 1100, 4'b1010, 1'b1, "extLast");
    expectAt(g2 + 1101, 4'b0000, 1'b0, "extDone");
    step(100);
    sensorIR_front = 1'b0;
    waitUntil(g2 + 1110);
    canMove = 1'b0;
    step(2);
    canMove = 1'b1;
    expectAt(cyc + 1, 4'b1010, 1'b1, "grant3");
    step(50);
    c = cyc;
    sensorIR_front = 1'b1;
    expectAt(c + 11, 4'b0000, 1'b1, "block3");
    expectAt(c + 310, 4'b0000, 1'b1, "blockLast");
    expectAt(c + 311, 4'b0000, 1'b0, "timeout");
    step(400);
    sensorIR_front = 1'b0;
    step(20);
    expectAt(cyc, 4'b0000, 1'b0, "doneHold");
    canMove = 1'b0;
    presentINs = 4'b0101;
    step(2);
    canMove = 1'b1;
    d = cyc;
    expectAt(d + 1, 4'b0000, 1'b1, "deadStart");
    expectAt(d + 20, 4'b0000, 1'b1, "deadLast");
    expectAt(d + 21, 4'b1010, 1'b1, "deadEnd");
    step(30);
    canMove = 1'b0;
    step(2);
    canMove = 1'b1;
    e = cyc;
    expectAt(e + 1, 4'b0000, 1'b1, "dead2");
    step(5);
    reset = 1'b1;
    expectAt(cyc + 1, 4'b0000, 1'b0, "resetMid");
    step(1);
    reset = 1'b0;
    canMove = 1'b0;
    step(2);
    expectAt(cyc, 4'b0000, 1'b0, "idleAfterReset");
    presentINs = 4'b0000;
    canMove = 1'b1;
    expectAt(cyc + 1, 4'b1010, 1'b1, "postReset");
    step(5);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard: %0d expectations never compared, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
